// File: rtl/high_address_responder.sv
// Single-outstanding request/response target with four 32-bit registers mapped
// at 0xFF000000..0xFF00000C and a configurable number of wait states.
module high_address_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned NUM_REGS = 4;

   localparam bit               HAS_WAIT  = (WAIT_CYCLES != 0);
   localparam logic [CNT_W-1:0] WAIT_LOAD = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                hold_write_q, hold_write_d;
   logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
   logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_error_q, rsp_error_d;
   logic                enter_resp;
   logic                txn_hit;
   logic [IDX_W-1:0]    txn_idx;

   // Register window: four word-aligned slots at the bottom of the 0xFF byte region.
   function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
      return (a[31:24] == 8'hFF) && (a[23:4] == 20'h0) && (a[1:0] == 2'b00);
   endfunction

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      regs_d       = regs_q;
      hold_write_d = hold_write_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_error_d  = rsp_error_q;
      enter_resp   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               hold_write_d = req_write;
               hold_addr_d  = req_addr;
               hold_wdata_d = req_wdata;
               if (HAS_WAIT) begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d     = S_IDLE;
               rsp_rdata_d = '0;
               rsp_error_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Decode from the captured copy so a zero-wait accept sees the same view.
      txn_hit = addr_hit(hold_addr_d);
      txn_idx = hold_addr_d[3:2];

      // Register access and response payload are committed once, on RESP entry.
      if (enter_resp) begin
         if (!txn_hit) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
         end else if (hold_write_d) begin
            regs_d[txn_idx] = hold_wdata_d;
            rsp_rdata_d     = '0;
            rsp_error_d     = 1'b0;
         end else begin
            rsp_rdata_d = regs_q[txn_idx];
            rsp_error_d = 1'b0;
         end
      end

      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         hold_write_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_wdata_q <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_error_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_write_q <= hold_write_d;
         hold_addr_q  <= hold_addr_d;
         hold_wdata_q <= hold_wdata_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_error_q  <= rsp_error_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule
